// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl: bit-serial unsigned magnitude comparator.
// A single g/l cascade cell is stepped over the operands MSB first.
// start/done handshake: start is sampled only while idle. Once it is accepted,
// busy stays high until the cycle after the one-cycle done pulse. Results on
// gt/lt/eq/cycles are valid with done and hold until the next completion.
module serial_compare_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1,
    parameter int CW         = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic [CW-1:0]    cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q, sb_q;
    logic             g_q, l_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, gt_q, lt_q, eq_q;
    logic [CW-1:0]    cycles_q;

    logic             x, y;
    logic             g_d, l_d;
    logic [CW-1:0]    cnt_d;
    logic             finish;

    // Cascade cell on the current MSBs. The scan ends when every bit has been
    // examined, or, with early exit, as soon as the first differing bit decides it.
    always_comb begin
        x      = sa_q[WIDTH-1];
        y      = sb_q[WIDTH-1];
        g_d    = g_q | (~l_q & x & ~y);
        l_d    = l_q | (~g_q & ~x & y);
        cnt_d  = cnt_q + CW'(1);
        finish = (cnt_d == CW'(WIDTH)) || (EARLY_EXIT && (g_d | l_d));
    end

    // Sequencer FSM with registered outputs; reset aborts any compare in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            g_q      <= 1'b0;
            l_q      <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            cycles_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        g_q     <= 1'b0;
                        l_q     <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    g_q   <= g_d;
                    l_q   <= l_d;
                    sa_q  <= sa_q << 1;
                    sb_q  <= sb_q << 1;
                    cnt_q <= cnt_d;
                    if (finish) begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        gt_q     <= g_d;
                        lt_q     <= l_d;
                        eq_q     <= ~(g_d | l_d);
                        cycles_q <= cnt_d;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign gt     = gt_q;
    assign lt     = lt_q;
    assign eq     = eq_q;
    assign cycles = cycles_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Bench for serial_compare_ctrl: four instances (8-bit and 4-bit, with and
// without early exit) are checked every cycle against a transaction-level model.
// Directed tests also pin the model with hand-computed literal results.
module tb_serial_compare_ctrl;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // ---------------- DUT signals ----------------
    logic [3:0] start_v;
    logic [7:0] a_v[4];
    logic [7:0] b_v[4];
    logic [3:0] busy_v, done_v, gt_v, lt_v, eq_v;
    logic [3:0] cyc0, cyc1;
    logic [2:0] cyc2, cyc3;
    logic [3:0] cyc_act[4];

    assign cyc_act[0] = cyc0;
    assign cyc_act[1] = cyc1;
    assign cyc_act[2] = {1'b0, cyc2};
    assign cyc_act[3] = {1'b0, cyc3};

    int vectors = 0;
    int fails   = 0;

    serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_w8e1 (
        .clock(clock), .reset(reset), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .gt(gt_v[0]), .lt(lt_v[0]), .eq(eq_v[0]),
        .cycles(cyc0));
    serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_w8e0 (
        .clock(clock), .reset(reset), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .gt(gt_v[1]), .lt(lt_v[1]), .eq(eq_v[1]),
        .cycles(cyc1));
    serial_compare_ctrl #(.WIDTH(4), .EARLY_EXIT(1'b1)) u_w4e1 (
        .clock(clock), .reset(reset), .start(start_v[2]), .a(a_v[2][3:0]), .b(b_v[2][3:0]),
        .busy(busy_v[2]), .done(done_v[2]), .gt(gt_v[2]), .lt(lt_v[2]), .eq(eq_v[2]),
        .cycles(cyc2));
    serial_compare_ctrl #(.WIDTH(4), .EARLY_EXIT(1'b0)) u_w4e0 (
        .clock(clock), .reset(reset), .start(start_v[3]), .a(a_v[3][3:0]), .b(b_v[3][3:0]),
        .busy(busy_v[3]), .done(done_v[3]), .gt(gt_v[3]), .lt(lt_v[3]), .eq(eq_v[3]),
        .cycles(cyc3));

    // ---------------- reference model ----------------
    function automatic int w_of(input int i);
        return (i < 2) ? 8 : 4;
    endfunction

    function automatic bit ee_of(input int i);
        return (i % 2) == 0;
    endfunction

    // Result of an unsigned compare and the number of bit positions a scan needs.
    task automatic ref_cmp(input int w, input bit ee, input logic [7:0] av, input logic [7:0] bv,
                           output int k, output logic g, output logic l, output logic e);
        int   leq;
        logic [7:0] mask;
        logic [7:0] am, bm;
        mask = 8'((1 << w) - 1);
        am   = av & mask;
        bm   = bv & mask;
        leq  = 0;
        for (int j = w - 1; j >= 0; j--) begin
            if (am[j] != bm[j]) break;
            leq++;
        end
        g = am > bm;
        l = am < bm;
        e = am == bm;
        if (!ee || leq >= w) k = w;
        else                 k = leq + 1;
    endtask

    int   cyc = 0;
    bit   active[4]  = '{0, 0, 0, 0};
    int   fin_edge[4];
    int   p_k[4];
    logic p_g[4], p_l[4], p_e[4];
    logic m_busy[4] = '{0, 0, 0, 0};
    logic m_done[4] = '{0, 0, 0, 0};
    logic m_gt[4]   = '{0, 0, 0, 0};
    logic m_lt[4]   = '{0, 0, 0, 0};
    logic m_eq[4]   = '{0, 0, 0, 0};
    int   m_cyc[4]  = '{0, 0, 0, 0};

    // Transaction timeline: accept at edge n, done at edge n+k, idle after n+k+1.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                active[i] = 0;
                m_busy[i] = 0;
                m_done[i] = 0;
                m_gt[i]   = 0;
                m_lt[i]   = 0;
                m_eq[i]   = 0;
                m_cyc[i]  = 0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 4; i++) begin
                m_done[i] = 0;
                if (active[i] && cyc == fin_edge[i]) begin
                    m_done[i] = 1;
                    m_gt[i]   = p_g[i];
                    m_lt[i]   = p_l[i];
                    m_eq[i]   = p_e[i];
                    m_cyc[i]  = p_k[i];
                end else if (active[i] && cyc == fin_edge[i] + 1) begin
                    active[i] = 0;
                    m_busy[i] = 0;
                end else if (!active[i] && start_v[i]) begin
                    ref_cmp(w_of(i), ee_of(i), a_v[i], b_v[i], p_k[i], p_g[i], p_l[i], p_e[i]);
                    fin_edge[i] = cyc + p_k[i];
                    active[i]   = 1;
                    m_busy[i]   = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        for (int i = 0; i < 4; i++) begin
            logic [8:0] exp_v, act_v;
            exp_v = {m_busy[i], m_done[i], m_gt[i], m_lt[i], m_eq[i], 4'(m_cyc[i])};
            act_v = {busy_v[i], done_v[i], gt_v[i], lt_v[i], eq_v[i], cyc_act[i]};
            vectors++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL model_dut%0d t=%0t busy,done,gt,lt,eq,cycles got %b required %b",
                         i, $time, act_v, exp_v);
            end
        end
    end

    // ---------------- driver / literal checks ----------------
    task automatic chk(input string name, input int act, input int exp_val);
        vectors++;
        if (act != exp_val) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, exp_val);
        end
    endtask

    task automatic run_only(input int i, input logic [7:0] av, input logic [7:0] bv,
                            output int lat);
        bit got;
        @(posedge clock);
        #1;
        start_v[i] = 1'b1;
        a_v[i]     = av;
        b_v[i]     = bv;
        lat        = 0;
        got        = 0;
        for (int t = 0; t < 25 && !got; t++) begin
            @(posedge clock);
            lat++;
            #1 start_v[i] = 1'b0;
            @(negedge clock);
            if (done_v[i]) got = 1;
        end
        if (!got) begin
            vectors++;
            fails++;
            $display("FAIL timeout_dut%0d a=%h b=%h: no done within 25 cycles", i, av, bv);
        end
    endtask

    task automatic run_cmp(input int i, input logic [7:0] av, input logic [7:0] bv,
                           input int e_lat, input int e_gt, input int e_lt, input int e_eq,
                           input int e_cyc);
        int    lat;
        string tag;
        run_only(i, av, bv, lat);
        tag = $sformatf("dut%0d %h/%h", i, av, bv);
        chk({tag, " latency"}, lat, e_lat);
        chk({tag, " done"}, int'(done_v[i]), 1);
        chk({tag, " gt"}, int'(gt_v[i]), e_gt);
        chk({tag, " lt"}, int'(lt_v[i]), e_lt);
        chk({tag, " eq"}, int'(eq_v[i]), e_eq);
        chk({tag, " cycles"}, int'(cyc_act[i]), e_cyc);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dcnt;
        int lat;
        reset   = 1'b1;
        start_v = '0;
        for (int i = 0; i < 4; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end
        @(negedge clock);
        chk("reset flags", int'({busy_v, done_v, gt_v, lt_v, eq_v}), 0);
        chk("reset cycles w8", int'(cyc0), 0);
        @(posedge clock);
        #2 reset = 1'b0;

        // Early exit on MSB, late exit, and full scan
        run_cmp(0, 8'h80, 8'h7F, 2, 1, 0, 0, 1);
        run_cmp(0, 8'h01, 8'h02, 8, 0, 1, 0, 7);
        run_cmp(1, 8'h01, 8'h02, 9, 0, 1, 0, 8);

        // Equal operands, then back-to-back start in the first idle cycle
        run_cmp(0, 8'hA5, 8'hA5, 9, 0, 0, 1, 8);
        run_cmp(0, 8'h00, 8'hFF, 2, 0, 1, 0, 1);
        run_cmp(1, 8'hA5, 8'hA5, 9, 0, 0, 1, 8);
        run_cmp(1, 8'h00, 8'hFF, 9, 0, 1, 0, 8);

        // start held high with operands changing every cycle: accepts every 10 cycles
        @(posedge clock);
        #1;
        start_v[1] = 1'b1;
        dcnt = 0;
        for (int j = 0; j < 30; j++) begin
            a_v[1] = 8'(j * 7);
            b_v[1] = 8'h55 ^ 8'(j);
            @(posedge clock);
            @(negedge clock);
            if (done_v[1]) dcnt++;
        end
        start_v[1] = 1'b0;
        chk("held start done count", dcnt, 3);
        repeat (12) @(posedge clock);

        // Reset during RUN cycle 3 aborts the compare
        #1;
        start_v[0] = 1'b1;
        a_v[0]     = 8'h01;
        b_v[0]     = 8'h02;
        @(posedge clock);
        #1 start_v[0] = 1'b0;
        repeat (3) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk("async reset flags", int'({busy_v[0], done_v[0], gt_v[0], lt_v[0], eq_v[0]}), 0);
        chk("async reset cycles", int'(cyc0), 0);
        @(posedge clock);
        #2 reset = 1'b0;
        dcnt = 0;
        repeat (10) begin
            @(negedge clock);
            if (done_v[0]) dcnt++;
        end
        chk("no done after abort", dcnt, 0);
        run_cmp(0, 8'h10, 8'h10, 9, 0, 0, 1, 8);

        // 4-bit literal points
        run_cmp(2, 8'h09, 8'h08, 5, 1, 0, 0, 4);
        run_cmp(2, 8'h03, 8'h04, 3, 0, 1, 0, 2);
        run_cmp(3, 8'h03, 8'h04, 5, 0, 1, 0, 4);

        // Exhaustive 4-bit sweep, both early-exit settings
        for (int i = 2; i < 4; i++) begin
            for (int av = 0; av < 16; av++) begin
                for (int bv = 0; bv < 16; bv++) begin
                    run_only(i, 8'(av), 8'(bv), lat);
                end
            end
        end

        repeat (4) @(posedge clock);
        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
